// File: rtl/countdown_display.sv
// Countdown display: converts the controller's time_left to BCD with a sequential
// double-dabble engine. Optional blinking of small values under COUNTDOWN_BLINK_EN.
module countdown_display #(
  parameter logic [1:0] RED    = 2'd0,
  parameter logic [1:0] GREEN  = 2'd1,
  parameter logic [1:0] YELLOW = 2'd2
`ifdef COUNTDOWN_BLINK_EN
  ,
  parameter int BLINK_THRESH = 5,
  parameter int BLINK_PERIOD = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] time_in,
  input  logic [1:0] light_in,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] color,
  output logic       disp_valid,
  output logic       busy,
  output logic       blank,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [17:0] shift_reg;
  logic [17:0] shift_next;
  logic [7:0]  bcd_adj;
  logic [7:0]  last_time_reg;
  logic [1:0]  light_cap_reg;
  logic [1:0]  light_map;
  logic [2:0]  cnt_reg;
  logic        publish_reg;
  logic        start;
  logic        load_en;
  logic        shift_en;
  logic        done_en;
  logic [9:0]  disp_value;

  assign start = (time_in != last_time_reg);

  // An undefined light code is shown as RED rather than passed through.
  assign light_map = ((light_in == GREEN) || (light_in == YELLOW)) ? light_in : RED;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    done_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load_en    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_reg == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on the ones and tens nibbles before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (shift_reg[8 + gi*4 +: 4] >= 4'd5)
                                  ? shift_reg[8 + gi*4 +: 4] + 4'd3
                                  : shift_reg[8 + gi*4 +: 4];
    end
  endgenerate

  assign shift_next = {shift_reg[16], bcd_adj, shift_reg[7:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg     <= 18'd0;
      last_time_reg <= 8'd0;
      light_cap_reg <= RED;
      cnt_reg       <= 3'd0;
      publish_reg   <= 1'b0;
      busy          <= 1'b0;
      disp_valid    <= 1'b0;
      hundreds      <= 2'd0;
      tens          <= 4'd0;
      ones          <= 4'd0;
      color         <= RED;
    end else begin
      // Outputs publish one cycle after DONE, so busy falls exactly as disp_valid rises.
      busy        <= (state_reg != IDLE);
      publish_reg <= done_en;
      disp_valid  <= publish_reg;
      if (publish_reg) begin
        hundreds <= shift_reg[17:16];
        tens     <= shift_reg[15:12];
        ones     <= shift_reg[11:8];
        color    <= light_cap_reg;
      end
      if (load_en) begin
        shift_reg     <= {10'd0, time_in};
        light_cap_reg <= light_map;
        last_time_reg <= time_in;
        cnt_reg       <= 3'd0;
      end else if (shift_en) begin
        shift_reg <= shift_next;
        cnt_reg   <= cnt_reg + 3'd1;
      end
    end
  end

  assign disp_value = 10'(hundreds) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);

  assign p1 = (tens > 4'd9) || (ones > 4'd9);
  assign p2 = (hundreds > 2'd2);
  assign p3 = disp_valid && busy;
  assign p4 = (color == YELLOW) && (disp_value > 10'd5);

`ifdef COUNTDOWN_BLINK_EN
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_wrap;
  logic          in_window;

  assign blink_wrap = (blink_cnt_reg == BW'(BLINK_PERIOD - 1));
  assign in_window  = (disp_value != 10'd0) && (disp_value <= 10'(BLINK_THRESH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_reg <= '0;
      blank         <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
      if (!in_window) begin
        blank <= 1'b0;
      end else if (blink_wrap) begin
        blank <= ~blank;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Sits directly downstream of the traffic-light controller.
- Consumes its `time_left` count and light colour.
- Converts the count to BCD with a sequential double-dabble engine and drives a 3-digit countdown display with colour tag.
- Exposes property outputs for SoCV model checking, in the same style as the controller.

Parameters:
- RED, 0, light encoding for red
- GREEN, 1, light encoding for green
- YELLOW, 2, light encoding for yellow
- BLINK_THRESH, 5, displayed value at or below which blinking is enabled (BLINK_EN only)
- BLINK_PERIOD, 4, cycles per blank toggle (BLINK_EN only)

Ports:
- clk  input  1  clock, all state on posedge
- reset  input  1  synchronous, active-low
- time_in  input  8  remaining-time count from the controller
- light_in  input  2  current light from the controller
- hundreds  output  2  BCD hundreds digit (0..2)
- tens  output  4  BCD tens digit
- ones  output  4  BCD ones digit
- color  output  2  light captured together with the displayed value
- disp_valid  output  1  one-cycle pulse: new digits/colour on outputs
- busy  output  1  conversion in progress
- blank  output  1  display blank request
- p1  output  1  property: tens>9 or ones>9
- p2  output  1  property: hundreds>2
- p3  output  1  property: disp_valid && busy
- p4  output  1  property: color==YELLOW and displayed value >5

Behaviour:
- Reset, reset==0 at posedge:
  - state=IDLE
  - hundreds/tens/ones=0, color=RED
  - disp_valid=0, busy=0, blank=0
  - last_time=0, shift counter=0
  - Reset mid-conversion aborts the conversion with no output update.
- States IDLE, SHIFT, DONE. Internal 18-bit shift register: {bcd[9:0], bin[7:0]}.
- IDLE:
  - If time_in != last_time: load bin=time_in, bcd=0, light_cap=light_in, last_time=time_in, cnt=0; go SHIFT; busy=1 from next cycle.
  - Otherwise remain in IDLE.
- SHIFT, one bit per cycle:
  - Add 3 to each bcd nibble (ones, tens) that is >=5.
  - Then shift the whole register left by 1.
  - cnt increments each cycle; after the 8th shift (cnt==7) go DONE. Exactly 8 SHIFT cycles.
- DONE, one cycle:
  - hundreds/tens/ones <= bcd; color <= light_cap.
  - disp_valid=1 in the following cycle only.
  - busy=0 in the following cycle; go IDLE.
- Latency:
  - Change sampled at edge N → outputs updated at edge N+10.
  - disp_valid high for cycle N+10..N+11.
  - busy high for cycles N+1..N+10 (edge N+1 through edge N+10).
- time_in changes while busy are ignored; the next IDLE compares against the current time_in, so the latest value wins and intermediate values are dropped.
- Simultaneous time_in and light_in change is captured atomically in the same cycle.
- Outputs hold between updates.
- Arithmetic is all unsigned. Max input 255 → 2/5/5.
- p1..p4 are combinational from registered outputs and must never assert in a correct design.

Optional Feature:
- Macro COUNTDOWN_BLINK_EN.
- Defined:
  - Free-running blink counter (0..BLINK_PERIOD-1, wraps).
  - blank toggles each wrap while the displayed value <= BLINK_THRESH and != 0.
  - blank is forced 0 otherwise, and cleared to 0 on reset or when the value leaves the window.
- Undefined: blank tied to 0; no blink counter is instantiated.

Test Plan:
- Reset held 3 cycles, time_in=0 → all outputs 0, color=RED, busy=0, no disp_valid.
- time_in 0→60, light=GREEN at edge N → busy from N+1; at N+10 digits 0/6/0, color=GREEN, disp_valid one cycle.
- time_in=255 → digits 2/5/5; p1=p2=0.
- time_in changes to 40, then 39 and 38 during conversion → 40 displayed first; next conversion shows 38 (39 dropped).
- reset asserted at 4th SHIFT cycle → outputs return to reset values; no disp_valid; restart after release.
- COUNTDOWN_BLINK_EN: display 3 → blank toggles every 4 cycles. Display 40 → blank=0. Undefined macro → blank always 0.
